// File: rtl/video_crop_pkg.sv
// Shared widths, FSM state type and configuration record for the vertical crop scheduler.
package video_crop_pkg;
  localparam int CROP_SIZE_W = 10;
  localparam int CROP_OFF_W  = 5;

  typedef enum logic [2:0] {IDLE, ARM, APPLY, RAMP, SETTLE} crop_state_t;

  typedef struct packed {
    logic        [CROP_SIZE_W-1:0] size;
    logic signed [CROP_OFF_W-1:0]  off;
  } crop_cfg_t;
endpackage

// File: rtl/video_crop_sched_vs_edge.sv
// CE-qualified rising-edge detector on vertical sync; emits a one-cycle vs tick.
module vs_edge_ce (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ce,
  input  logic i_vs,
  output logic o_tick
);
  logic r_old_vs;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_old_vs <= 1'b0;
    end else if (i_ce) begin
      r_old_vs <= i_vs;
    end
  end

  assign o_tick = i_ce && i_vs && !r_old_vs;
endmodule

// File: rtl/video_crop_sched.sv
// Frame-synchronous crop scheduler: arbitrates HPS/core requests, commits on vsync, ramps offset.
module video_crop_sched #(
  parameter bit          RAMP          = 1'b1,
  parameter int unsigned SETTLE_FRAMES = 2
) (
  input  logic                                  CLK_VIDEO,
  input  logic                                  RESET,
  input  logic                                  CE_PIXEL,
  input  logic                                  VGA_VS,
  input  logic                                  HPS_REQ,
  input  logic [video_crop_pkg::CROP_SIZE_W-1:0] HPS_SIZE,
  input  logic [video_crop_pkg::CROP_OFF_W-1:0]  HPS_OFF,
  output logic                                  HPS_ACK,
  input  logic                                  CORE_REQ,
  input  logic [video_crop_pkg::CROP_SIZE_W-1:0] CORE_SIZE,
  input  logic [video_crop_pkg::CROP_OFF_W-1:0]  CORE_OFF,
  output logic                                  CORE_ACK,
  output logic [video_crop_pkg::CROP_SIZE_W-1:0] CROP_SIZE,
  output logic [video_crop_pkg::CROP_OFF_W-1:0]  CROP_OFF,
  output logic                                  BUSY
);
  import video_crop_pkg::crop_state_t;
  import video_crop_pkg::crop_cfg_t;
  import video_crop_pkg::IDLE;
  import video_crop_pkg::ARM;
  import video_crop_pkg::APPLY;
  import video_crop_pkg::SETTLE;

  localparam logic [3:0] SETTLE_N = 4'(SETTLE_FRAMES);

  crop_state_t r_state, w_next_state;
  crop_cfg_t   r_tgt;
  logic [3:0]  r_cnt;
  logic        r_hps_ack, r_core_ack;
  logic [video_crop_pkg::CROP_SIZE_W-1:0] r_crop_size;
  logic [video_crop_pkg::CROP_OFF_W-1:0]  r_crop_off, w_off_nxt;
  logic        w_tick, w_grant_hps, w_grant_core, w_commit_size;
  logic        w_off_load, w_off_step, w_cnt_clr, w_cnt_inc;

  vs_edge_ce u_vs_edge (
    .i_clk  (CLK_VIDEO),
    .i_rst  (RESET),
    .i_ce   (CE_PIXEL),
    .i_vs   (VGA_VS),
    .o_tick (w_tick)
  );

  always_comb begin
    w_next_state  = r_state;
    w_grant_hps   = 1'b0;
    w_grant_core  = 1'b0;
    w_commit_size = 1'b0;
    w_off_load    = 1'b0;
    w_off_step    = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_off_nxt     = ($signed(r_crop_off) < $signed(r_tgt.off)) ? r_crop_off + 5'd1
                                                              : r_crop_off - 5'd1;
    case (r_state)
      IDLE: begin
        if (HPS_REQ) begin
          w_grant_hps  = 1'b1;
          w_next_state = ARM;
        end else if (CORE_REQ) begin
          w_grant_core = 1'b1;
          w_next_state = ARM;
        end
      end
      // A tick during the ACK cycle is ignored so a full frame separates grant and commit.
      ARM: begin
        if (w_tick && !(r_hps_ack || r_core_ack)) w_next_state = APPLY;
      end
      APPLY: begin
        w_commit_size = 1'b1;
        if (!RAMP || (r_crop_off == r_tgt.off)) begin
          w_off_load   = 1'b1;
          w_cnt_clr    = 1'b1;
          w_next_state = SETTLE;
        end else begin
          w_next_state = video_crop_pkg::RAMP;
        end
      end
      video_crop_pkg::RAMP: begin
        if (w_tick) begin
          w_off_step = 1'b1;
          if (w_off_nxt == r_tgt.off) begin
            w_cnt_clr    = 1'b1;
            w_next_state = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (r_cnt == SETTLE_N)   w_next_state = IDLE;
        else if (w_tick)         w_cnt_inc    = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_tgt       <= '0;
      r_cnt       <= '0;
      r_hps_ack   <= 1'b0;
      r_core_ack  <= 1'b0;
      r_crop_size <= '0;
      r_crop_off  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_hps_ack  <= w_grant_hps;
      r_core_ack <= w_grant_core;
      if (w_grant_hps)       r_tgt <= '{size: HPS_SIZE,  off: HPS_OFF};
      else if (w_grant_core) r_tgt <= '{size: CORE_SIZE, off: CORE_OFF};
      if (w_commit_size)     r_crop_size <= r_tgt.size;
      if (w_off_load)        r_crop_off  <= r_tgt.off;
      else if (w_off_step)   r_crop_off  <= w_off_nxt;
      if (w_cnt_clr)         r_cnt <= '0;
      else if (w_cnt_inc)    r_cnt <= r_cnt + 4'd1;
    end
  end

  assign HPS_ACK   = r_hps_ack;
  assign CORE_ACK  = r_core_ack;
  assign CROP_SIZE = r_crop_size;
  assign CROP_OFF  = r_crop_off;
  assign BUSY      = (r_state != IDLE);
endmodule

// File: doc/video_crop_sched.md
# video_crop_sched

Frame-synchronous scheduler for the vertical crop stage. It arbitrates crop-configuration requests from two requesters, the HPS/OSD menu and the core's auto-crop logic. It commits the granted size only on a vertical-sync boundary and ramps the vertical offset one line-step per frame, so the picture never tears or jumps mid-frame. Its outputs drive the crop stage's CROP_SIZE/CROP_OFF inputs directly, in the CLK_VIDEO domain.

## Interface
- RAMP, default 1: 1 = step CROP_OFF by ±1 per frame toward target; 0 = apply offset together with size.
- SETTLE_FRAMES, default 2: frames held busy after final commit before the next grant. Range 0..15.

- CLK_VIDEO  in  1  video clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- CE_PIXEL  in  1  pixel enable; VGA_VS is sampled only when high.
- VGA_VS  in  1  vertical sync, active-high.
- HPS_REQ  in  1  HPS request; level, held until HPS_ACK.
- HPS_SIZE  in  10  requested crop size in lines; 0 = crop disabled.
- HPS_OFF  in  5  requested offset, signed two's complement (-16..15).
- HPS_ACK  out  1  one-cycle grant pulse; HPS_SIZE/HPS_OFF are captured in this cycle.
- CORE_REQ, CORE_SIZE[9:0], CORE_OFF[4:0], CORE_ACK: same as the HPS set, for the core requester.
- CROP_SIZE  out  10  committed crop size (registered).
- CROP_OFF  out  5  committed signed offset (registered).
- BUSY  out  1  high whenever state ≠ IDLE.

## Operation
- vs_tick: on a cycle with CE_PIXEL=1 and VGA_VS=1, where VGA_VS was 0 at the previous CE_PIXEL sample.
  - One CLK_VIDEO cycle wide.
  - The history register old_vs updates only when CE_PIXEL=1.
- The FSM has five states: IDLE, ARM, APPLY, RAMP, SETTLE.
- IDLE:
  - Grant priority is fixed: HPS over CORE.
  - On a grant, pulse the matching ACK, latch tgt_size/tgt_off, and go to ARM.
  - If both requests are high, only HPS_ACK fires; CORE stays pending.
- ARM:
  - Wait for vs_tick, then go to APPLY.
  - A vs_tick in the same cycle as the grant does not count; at least one full frame separates grant and commit.
- APPLY (one cycle):
  - CROP_SIZE <= tgt_size.
  - If RAMP=0 or CROP_OFF == tgt_off: CROP_OFF <= tgt_off, then go to SETTLE.
  - Otherwise go to RAMP.
- RAMP:
  - On each vs_tick, CROP_OFF steps ±1 toward tgt_off, using signed comparison.
  - When CROP_OFF reaches tgt_off, go to SETTLE.
  - The first step happens on the vs_tick after APPLY.
- SETTLE:
  - Clear a 4-bit frame counter on entry; increment it on each vs_tick.
  - Go to IDLE when the counter reaches SETTLE_FRAMES.
  - If SETTLE_FRAMES=0, go to IDLE on the cycle after entry.
- Requests arriving outside IDLE are not acknowledged and stay pending; requesters hold REQ.
- A request equal to the current configuration still runs the full sequence: ACK, commit, settle.
- Reset, asserted at any time (including mid-RAMP):
  - State = IDLE.
  - CROP_SIZE = 0, CROP_OFF = 0 (crop disabled).
  - HPS_ACK = CORE_ACK = 0, BUSY = 0.
  - old_vs = 0, counter = 0.
  - Partially ramped offsets are discarded.

## Timing
- Grant latency: ACK is registered, high in the cycle after REQ is first seen high in IDLE. BUSY rises with ACK.
- Commit latency: CROP_SIZE changes 2 cycles after the first qualifying vs_tick (vs_tick → APPLY → output register).
- Ramp: |tgt_off − CROP_OFF| frames after APPLY; worst case 31 frames (-16 → 15).
- The back-to-back grant gap is at least 1 + ramp + SETTLE_FRAMES frames.
- Outputs change only within 2 cycles after a vs_tick, never mid-active-video.

## Structure
- Package video_crop_pkg holds:
  - CROP_SIZE_W = 10 and CROP_OFF_W = 5.
  - typedef enum logic [2:0] crop_state_t {IDLE, ARM, APPLY, RAMP, SETTLE}.
  - typedef struct {size, off} crop_cfg_t.
- Sub-module vs_edge_ce (CE-qualified rising-edge detector producing vs_tick) is natural; the crop stage can reuse it.
- Everything else lives in a single module: arbiter, FSM, ramp, counter.

## Test plan
- Simple grant, RAMP=1, SETTLE_FRAMES=2, reset state:
  - Stimulus: HPS_REQ with size 224, off 0.
  - Response: HPS_ACK after 1 cycle; CROP_SIZE=224 two cycles after the next vs_tick; BUSY low 2 vs_ticks later.
- Simultaneous requests:
  - Stimulus: HPS (240, 0) and CORE (200, 3) asserted in the same cycle.
  - Response: HPS_ACK only; the CORE grant comes after HPS settles; final CROP_SIZE=200, CROP_OFF=3.
- Negative ramp:
  - Stimulus: from off=+2, request off=-3.
  - Response: CROP_OFF goes 2→1→0→-1→-2→-3, one step per vs_tick; CROP_SIZE is committed at APPLY, before the first step.
- Grant/VS collision:
  - Stimulus: REQ asserted so the grant coincides with vs_tick.
  - Response: no commit on that vs_tick; commit on the next one.
- CE gating:
  - Stimulus: VGA_VS toggling while CE_PIXEL=0.
  - Response: no vs_tick; state stays ARM.
- Reset mid-RAMP:
  - Stimulus: assert RESET asynchronously during a ramp from 0 to 10.
  - Response: outputs immediately 0, BUSY=0; a held REQ is re-granted after release.
